cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
- Multi-cycle fetch/execute controller for the 9-bit CPU.
- Drives the instruction-memory address from an internal PC and latches the 9-bit instruction word {op[8:4], operand[3:0]}.
- Issues a one-cycle execute strobe to the datapath, resolves conditional jumps/branches, and sequences load/store through a req/ack data-memory handshake with timeout.
- Sits between instruction ROM, register-file/ALU datapath and data memory; owns the `done` halt condition.

Parameters:
- PC_W, 10, width of program counter and instruction address.
- MEM_TIMEOUT, 15, max cycles in MEM without mem_ack before fault (>=1).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin execution at start_pc; sampled only in IDLE, HALT, FAULT
- start_pc  in  PC_W  initial PC loaded on accepted start
- imem_addr  out  PC_W  instruction address, always equals pc
- imem_data  in  9  instruction word, valid the cycle after imem_addr (registered ROM)
- pc  out  PC_W  current program counter
- ir  out  9  latched instruction
- exec_en  out  1  one-cycle strobe: datapath executes ir
- zero  in  1  datapath zero flag, sampled in EXEC
- branch_target  in  PC_W  target for taken jizr/jnzr/bizr/bnzr, sampled in EXEC
- mem_req  out  1  data-memory request, held through MEM
- mem_we  out  1  1 = store, 0 = load; valid while mem_req
- mem_ack  in  1  data-memory completion
- busy  out  1  high in FETCH/LATCH/EXEC/MEM
- halted  out  1  high in HALT
- fault  out  1  high in FAULT

Behaviour:
- Opcode encoding (op[8:4]):
  - load=16, stor=17, jizr=20, jnzr=21, bizr=22, bnzr=23, func=31.
  - func operand 15 = done; all other func operands (incl. ndne=14) and all other opcodes are "plain".
- Reset:
  - State = IDLE, pc=0, ir=0, counter=0.
  - exec_en, mem_req, mem_we, busy, halted, fault all 0.
  - Reset mid-operation aborts immediately; no further exec_en or mem_req.
- States: IDLE, FETCH, LATCH, EXEC, MEM, HALT, FAULT.
- IDLE: start=1 -> pc<=start_pc, go FETCH.
- FETCH: 1 cycle, imem_addr=pc -> LATCH.
- LATCH: ir<=imem_data -> EXEC.
- EXEC: exec_en=1 for exactly this cycle.
  - load/stor: -> MEM, counter<=0; pc unchanged.
  - func done: -> HALT; pc unchanged (points at the done instruction).
  - jizr/bizr: zero=1 -> pc<=branch_target, else pc<=pc+1; -> FETCH.
  - jnzr/bnzr: zero=0 -> pc<=branch_target, else pc<=pc+1; -> FETCH.
  - plain: pc<=pc+1 -> FETCH.
- Non-memory instruction period = 3 cycles (FETCH, LATCH, EXEC).
- MEM:
  - mem_req=1; mem_we=(ir op==stor) is registered on entry and stable for the whole MEM stay.
  - mem_ack=1 -> pc<=pc+1, -> FETCH (mem_req drops next cycle).
  - Otherwise counter++; if counter==MEM_TIMEOUT-1 with no ack -> FAULT.
  - Ack in the same cycle as the timeout condition wins, so fault = exactly MEM_TIMEOUT consecutive cycles without ack.
  - Minimum load/store period = 4 cycles (zero-wait ack).
- HALT:
  - halted=1; start -> clear halted, pc<=start_pc, FETCH.
  - First fetch cycle after restart has halted=0, busy=1.
- FAULT:
  - fault=1, busy=0, pc and ir frozen; only reset or start exits.
  - start clears fault, same transition as HALT.
- Ignored inputs:
  - start ignored while busy.
  - mem_ack ignored outside MEM.
  - zero and branch_target ignored outside EXEC.
- pc arithmetic is modulo 2^PC_W: pc+1 from all-ones wraps to 0.
- exec_en never asserts in two consecutive cycles.
- mem_req never asserts outside MEM.

Test Plan:
- Reset, start=1 with start_pc=5, ROM[5]=9'h000, ROM[6]=9'h1FF -> imem_addr 5,5,5 then 6; one exec_en per instruction; halted=1 from 6th cycle after start with pc=6; busy=0.
- jizr (9'h140) at pc=3, branch_target=40: zero=1 -> next fetch addr 40; zero=0 -> next fetch addr 4.
- stor (9'h110) with mem_ack after 2 wait cycles -> mem_req high 3 cycles, mem_we=1 throughout; pc 7->8; load (9'h100) -> mem_we=0.
- MEM_TIMEOUT=4, load with no ack -> fault=1 after exactly 4 MEM cycles; repeat with ack on 4th cycle -> no fault, pc advances; start afterwards clears fault.
- PC_W=4, plain instruction at pc=15 -> next fetch at 0; start pulsed while busy -> no effect on pc.
- Reset asserted during MEM with mem_req=1 -> next cycle mem_req=0, pc=0, state IDLE; a late mem_ack is ignored.

Source files
------------

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle fetch/execute controller for the 9-bit CPU. Owns the program
// counter, addresses the registered instruction ROM, latches the instruction
// word {op[8:4], operand[3:0]}, strobes the datapath once per instruction,
// resolves conditional jumps/branches and runs a req/ack handshake with a
// timeout for load/store.
//
// Ports
//   clk            in   clock, all state on rising edge
//   reset          in   synchronous active-high reset
//   start          in   begin execution at start_pc (IDLE/HALT/FAULT only)
//   start_pc       in   PC loaded on an accepted start
//   imem_addr      out  instruction address (always equals pc)
//   imem_data      in   instruction word, valid the cycle after imem_addr
//   pc             out  current program counter
//   ir             out  latched instruction
//   exec_en        out  one-cycle execute strobe to the datapath
//   zero           in   datapath zero flag, used in EXEC only
//   branch_target  in   target for taken conditional jumps, EXEC only
//   mem_req        out  data-memory request, held for the whole MEM stay
//   mem_we         out  1 = store, 0 = load, valid while mem_req
//   mem_ack        in   data-memory completion, used in MEM only
//   busy           out  high in FETCH/LATCH/EXEC/MEM
//   halted         out  high in HALT
//   fault          out  high in FAULT (memory timeout)
//
// State table
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   FETCH   | imem_addr = pc presented to the ROM
//   LATCH   | ROM output valid, ir captured
//   EXEC    | exec_en pulse, next pc / next state resolved
//   MEM     | load/store handshake, timeout counter running
//   HALT    | done instruction executed, waiting for start
//   FAULT   | MEM_TIMEOUT cycles without ack, waiting for start
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int PC_W        = 10,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  output logic [PC_W-1:0] pc,
  output logic [8:0]      ir,
  output logic            exec_en,
  input  logic            zero,
  input  logic [PC_W-1:0] branch_target,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic            busy,
  output logic            halted,
  output logic            fault
);

  // Counter only needs to reach MEM_TIMEOUT-1.
  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [4:0] OP_LOAD = 5'd16;
  localparam logic [4:0] OP_STOR = 5'd17;
  localparam logic [4:0] OP_JIZR = 5'd20;
  localparam logic [4:0] OP_JNZR = 5'd21;
  localparam logic [4:0] OP_BIZR = 5'd22;
  localparam logic [4:0] OP_BNZR = 5'd23;
  localparam logic [4:0] OP_FUNC = 5'd31;
  localparam logic [3:0] FN_DONE = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_MEM,
    S_HALT,
    S_FAULT
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [8:0]      r_ir;
  logic [CNT_W-1:0] r_cnt;
  logic            r_exec_en;
  logic            r_mem_req;
  logic            r_mem_we;
  logic            r_busy;
  logic            r_halted;
  logic            r_fault;

  logic [4:0]      w_op;
  logic            w_is_mem;
  logic            w_is_stor;
  logic            w_is_done;
  logic            w_take;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_next;

  assign w_op      = r_ir[8:4];
  assign w_is_stor = (w_op == OP_STOR);
  assign w_is_mem  = (w_op == OP_LOAD) || w_is_stor;
  assign w_is_done = (w_op == OP_FUNC) && (r_ir[3:0] == FN_DONE);
  // Wraps modulo 2^PC_W by construction.
  assign w_pc_inc  = r_pc + PC_W'(1);

  always_comb begin
    w_take = 1'b0;
    case (w_op)
      OP_JIZR, OP_BIZR: w_take = zero;
      OP_JNZR, OP_BNZR: w_take = ~zero;
      default:          w_take = 1'b0;
    endcase
  end

  assign w_pc_next = w_take ? branch_target : w_pc_inc;

  // Outputs are registered alongside the state so each one is a clean flop
  // that changes together with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_cnt     <= '0;
      r_exec_en <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_exec_en <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT, S_FAULT: begin
          if (start) begin
            r_pc     <= start_pc;
            r_state  <= S_FETCH;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
          end
        end

        S_FETCH: begin
          r_state <= S_LATCH;
        end

        S_LATCH: begin
          r_ir      <= imem_data;
          r_state   <= S_EXEC;
          r_exec_en <= 1'b1;
        end

        S_EXEC: begin
          if (w_is_mem) begin
            r_state   <= S_MEM;
            r_cnt     <= '0;
            r_mem_req <= 1'b1;
            r_mem_we  <= w_is_stor;
          end else if (w_is_done) begin
            // pc stays on the done instruction.
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_pc    <= w_pc_next;
            r_state <= S_FETCH;
          end
        end

        S_MEM: begin
          // Ack is checked first so an ack on the last allowed cycle wins
          // over the timeout.
          if (mem_ack) begin
            r_pc      <= w_pc_inc;
            r_state   <= S_FETCH;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= S_FAULT;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_busy    <= 1'b0;
            r_fault   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_busy    <= 1'b0;
          r_halted  <= 1'b0;
          r_fault   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign exec_en   = r_exec_en;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign fault     = r_fault;

endmodule
